spi_master_tx: RTL and testbench

- SPI mode-0 initiator: the transmit end of the 32-bit MSB-first SPI link whose receiver shifts MOSI on SCLK rising edges while SS_N is low.
- Accepts a word over a valid/ready handshake, drives SCLK/SS_N/MOSI at a programmable rate, samples MISO, and returns the received word with a one-cycle strobe.
- Sits on the controller side (test harness or companion die) and drives the motor-controller SPI pads.

---
 rtl/spi_master_tx.sv | 156 +++++++++++++++
 tb/tb_spi_master_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmit-side initiator: sends a DATA_WIDTH word MSB-first on
// mosi, samples miso on each sclk rise, and returns the received word with a
// one-cycle rx_valid strobe. Every output is a flop.
module spi_master_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4,
    parameter int SS_SETUP   = 4,
    parameter int SS_HOLD    = 4,
    parameter int SS_GAP     = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  ss_n,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int CNT_W = 16;
    localparam int BIT_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLK_DIV - 1);
    // HOLD first completes the final low half-period of sclk, then keeps
    // ss_n low for SS_HOLD more clocks.
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(CLK_DIV + SS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(SS_GAP - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
    // tx_sr holds only the bits not yet presented on mosi
    logic [DATA_WIDTH-2:0] tx_sr, tx_sr_nxt;
    logic [DATA_WIDTH-1:0] rx_sr, rx_sr_nxt, rx_data_nxt;
    logic                  sclk_nxt, ss_n_nxt, mosi_nxt, rx_valid_nxt;
    logic [1:0]            miso_sync;

    // Two-flop synchroniser for the asynchronous miso input
    always_ff @(posedge clock) begin
        if (!reset_n) miso_sync <= '0;
        else          miso_sync <= {miso_sync[0], miso};
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + 1'b1;
        bit_cnt_nxt  = bit_cnt;
        tx_sr_nxt    = tx_sr;
        rx_sr_nxt    = rx_sr;
        rx_data_nxt  = rx_data;
        sclk_nxt     = sclk;
        ss_n_nxt     = ss_n;
        mosi_nxt     = mosi;
        rx_valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (tx_valid && tx_ready) begin
                    tx_sr_nxt   = tx_data[DATA_WIDTH-2:0];
                    mosi_nxt    = tx_data[DATA_WIDTH-1];
                    ss_n_nxt    = 1'b0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_END) begin
                    cnt_nxt   = '0;
                    sclk_nxt  = 1'b1;
                    rx_sr_nxt = {rx_sr[DATA_WIDTH-2:0], miso_sync[1]};
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (cnt == HALF_END) begin
                    cnt_nxt  = '0;
                    sclk_nxt = 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = HOLD;
                    end else begin
                        mosi_nxt    = tx_sr[DATA_WIDTH-2];
                        tx_sr_nxt   = {tx_sr[DATA_WIDTH-3:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        state_nxt   = LOW;
                    end
                end
            end
            LOW: begin
                if (cnt == HALF_END) begin
                    cnt_nxt   = '0;
                    sclk_nxt  = 1'b1;
                    rx_sr_nxt = {rx_sr[DATA_WIDTH-2:0], miso_sync[1]};
                    state_nxt = HIGH;
                end
            end
            HOLD: begin
                if (cnt == HOLD_END) begin
                    cnt_nxt      = '0;
                    ss_n_nxt     = 1'b1;
                    rx_data_nxt  = rx_sr;
                    rx_valid_nxt = 1'b1;
                    state_nxt    = GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_END) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transfer in flight
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            sclk     <= 1'b0;
            ss_n     <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tx_sr    <= tx_sr_nxt;
            rx_sr    <= rx_sr_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            sclk     <= sclk_nxt;
            ss_n     <= ss_n_nxt;
            mosi     <= mosi_nxt;
            busy     <= (state_nxt != IDLE);
            tx_ready <= (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed + randomized bench for spi_master_tx: loopback, co-simulated
// 3-flop-synchronised slave, back-to-back, mid-transfer reset, CLK_DIV=2.
module tb_spi_master_tx;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, rx_valid, busy, sclk, ss_n, mosi, miso;
    logic [DW-1:0] rx_data;

    logic [DW-1:0] tx_data2 = '0;
    logic          tx_valid2 = 1'b0;
    logic          tx_ready2, rx_valid2, busy2, sclk2, ss_n2, mosi2;
    logic [DW-1:0] rx_data2;

    int            miso_mode = 0;   // 0: loopback, 1: slave model
    logic [DW-1:0] slave_sr = '0;
    logic [DW-1:0] slave_init = '0;
    logic          slave_load = 1'b0;
    logic [3:0]    s_sclk = '0;
    logic [2:0]    s_ss = 3'b111;
    logic [2:0]    s_mosi = '0;

    assign miso = (miso_mode == 0) ? mosi : slave_sr[DW-1];

    spi_master_tx dut (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    spi_master_tx #(.CLK_DIV(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2),
        .sclk(sclk2), .ss_n(ss_n2), .mosi(mosi2), .miso(1'b1)
    );

    // Mode-0 slave: inputs through 3 flops, shift on synchronised sclk rise, miso = MSB
    always @(posedge clock) begin
        s_sclk <= {s_sclk[2:0], sclk};
        s_ss   <= {s_ss[1:0], ss_n};
        s_mosi <= {s_mosi[1:0], mosi};
        if (slave_load) slave_sr <= slave_init;
        else if (!s_ss[2] && s_sclk[2] && !s_sclk[3]) slave_sr <= {slave_sr[DW-2:0], s_mosi[2]};
    end

    // Bus monitor
    int rises = 0, rxv = 0, edge_viol = 0, rdy_viol = 0, low_run = 0, high_run = 0, last_gap = 0;
    int cyc = 0, rises2 = 0, rxv2 = 0, per2 = 0, last_rise2 = 0, edge_viol2 = 0;
    logic [DW-1:0] bits = '0;
    logic [DW-1:0] bits_q[$];
    logic [DW-1:0] rx_q[$];
    int lowlen_q[$];
    logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_ss = 1'b1, prev_sclk2 = 1'b0, prev_mosi2 = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (sclk && !prev_sclk) begin
            rises++;
            bits = {bits[DW-2:0], mosi};
            if (mosi !== prev_mosi) edge_viol++;
        end
        if (!ss_n) begin
            if (prev_ss) begin last_gap = high_run; low_run = 0; end
            low_run++;
            high_run = 0;
        end else begin
            if (!prev_ss) begin lowlen_q.push_back(low_run); bits_q.push_back(bits); end
            high_run++;
        end
        if (busy === tx_ready) rdy_viol++;
        if (rx_valid) begin rxv++; rx_q.push_back(rx_data); end
        if (sclk2 && !prev_sclk2) begin
            rises2++;
            per2 = cyc - last_rise2;
            last_rise2 = cyc;
            if (mosi2 !== prev_mosi2) edge_viol2++;
        end
        if (rx_valid2) rxv2++;
        prev_sclk = sclk; prev_mosi = mosi; prev_ss = ss_n;
        prev_sclk2 = sclk2; prev_mosi2 = mosi2;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [DW-1:0] word);
        int t = 0;
        while (!tx_ready && t < 2000) begin @(negedge clock); t++; end
        if (t >= 2000) chk("ready_timeout", 32'(tx_ready), 32'd1);
        tx_data  = word;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        tx_data  = $urandom;      // must not affect the word in flight
    endtask

    task automatic wait_rxv(input int target, input string tag);
        int t = 0;
        while (rxv < target && t < 3000) begin @(negedge clock); t++; end
        chk(tag, 32'(rxv >= target), 32'd1);
    endtask

    // One loopback transfer: the reference result is simply the word sent
    task automatic loop_xfer(input logic [DW-1:0] word, input string tag);
        int r0, n0;
        r0 = rises; n0 = rxv;
        start(word);
        wait_rxv(n0 + 1, {tag, "_done"});
        repeat (3) @(negedge clock);
        chk({tag, "_rises"}, 32'(rises - r0), 32'd32);
        chk({tag, "_rxv"}, 32'(rxv - n0), 32'd1);
        chk({tag, "_rx"}, rx_data, word);
        chk({tag, "_mosi"}, bits_q[bits_q.size()-1], word);
        chk({tag, "_sslow"}, 32'(lowlen_q[lowlen_q.size()-1]), 32'd264);
    endtask

    // Slave co-simulation: slave ends with the sent word, master gets slave's prior content
    task automatic slave_xfer(input logic [DW-1:0] word, input logic [DW-1:0] prior, input string tag);
        int n0;
        miso_mode = 1;
        slave_init = prior;
        slave_load = 1'b1;
        @(negedge clock);
        slave_load = 1'b0;
        n0 = rxv;
        start(word);
        wait_rxv(n0 + 1, {tag, "_done"});
        repeat (4) @(negedge clock);
        chk({tag, "_slave"}, slave_sr, word);
        chk({tag, "_rx"}, rx_data, prior);
        miso_mode = 0;
    endtask

    initial begin
        int t, n0, r0;
        logic [DW-1:0] w;

        // Reset and idle
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("idle_outputs", 32'({sclk, ss_n, mosi, tx_ready, busy, rx_valid}), 32'b010100);
        end
        chk("idle_rx_data", rx_data, 32'h0);

        // Loopback, directed then random words
        loop_xfer(32'hDEADBEEF, "loop_deadbeef");
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            loop_xfer(w, "loop_rand");
        end

        // Slave co-simulation
        slave_xfer(32'hA5A5_0F0F, $urandom, "slave_a5a5");
        slave_xfer($urandom, $urandom, "slave_rand");

        // Back-to-back with tx_valid held high
        n0 = rxv;
        tx_data = 32'h0000_0001;
        tx_valid = 1'b1;
        t = 0;
        while (!busy && t < 100) begin @(negedge clock); t++; end
        tx_data = 32'h8000_0000;
        wait_rxv(n0 + 1, "b2b_first");
        t = 0;
        while (busy && t < 100) begin @(negedge clock); t++; end
        while (!busy && t < 200) begin @(negedge clock); t++; end
        chk("b2b_restart", 32'(busy), 32'd1);
        tx_valid = 1'b0;
        tx_data = $urandom;
        wait_rxv(n0 + 2, "b2b_second");
        repeat (20) @(negedge clock);
        chk("b2b_rxv", 32'(rxv - n0), 32'd2);
        chk("b2b_rx0", rx_q[rx_q.size()-2], 32'h0000_0001);
        chk("b2b_rx1", rx_q[rx_q.size()-1], 32'h8000_0000);
        chk("b2b_gap", 32'(last_gap >= 5), 32'd1);
        chk("ready_vs_busy", 32'(rdy_viol), 32'd0);

        // Reset during bit 17
        r0 = rises;
        start($urandom);
        t = 0;
        while (rises - r0 < 18 && t < 2000) begin @(negedge clock); t++; end
        chk("abort_reach_bit17", 32'(rises - r0), 32'd18);
        n0 = rxv;
        reset_n = 1'b0;
        @(negedge clock);
        chk("abort_outputs", 32'({sclk, ss_n, tx_ready, busy, rx_valid}), 32'b01100);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("abort_no_rxv", 32'(rxv - n0), 32'd0);
        loop_xfer(32'h1234_5678, "after_abort");
        chk("mosi_on_rise", 32'(edge_viol), 32'd0);

        // CLK_DIV=2 instance with miso held high
        @(negedge clock);
        tx_data2 = $urandom;
        tx_valid2 = 1'b1;
        @(negedge clock);
        tx_valid2 = 1'b0;
        t = 0;
        while (rxv2 < 1 && t < 2000) begin @(negedge clock); t++; end
        chk("div2_done", 32'(rxv2), 32'd1);
        repeat (8) @(negedge clock);
        chk("div2_rx", rx_data2, 32'hFFFF_FFFF);
        chk("div2_period", 32'(per2), 32'd4);
        chk("div2_rises", 32'(rises2), 32'd32);
        chk("div2_mosi_on_rise", 32'(edge_viol2), 32'd0);
        chk("div2_idle", 32'({ss_n2, busy2, tx_ready2}), 32'b101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
